// File: rtl/mac_window.sv
// Windowed signed multiply-accumulate: bias + sum of KLEN products, two-stage pipeline, valid/ready on both sides.
// Build option: define MAC_WINDOW_SAT_EN to saturate out_data to OUT_W bits instead of wrapping.
module mac_window #(
    parameter int A_W   = 16,
    parameter int B_W   = 16,
    parameter int C_W   = 28,
    parameter int ACC_W = 40,
    parameter int OUT_W = 33,
    parameter int KLEN  = 25
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sclr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    input  logic signed [C_W-1:0]   bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data
);
    localparam int P_W = A_W + B_W;
    localparam int CNT_W = (KLEN > 1) ? $clog2(KLEN) : 1;
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(KLEN - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic signed [P_W-1:0]   p_r;
    logic                    p_vld, p_first, p_last;
    logic signed [C_W-1:0]   bias_r;
    logic signed [ACC_W-1:0] acc_reg, acc_sum;
    logic signed [P_W-1:0]   prod;
    logic signed [OUT_W-1:0] result;
    logic                    stall, advance, accept, term_first, term_last;

    assign stall      = out_valid & ~out_ready;
    assign advance    = en & ~stall & ~sclr;
    assign in_ready   = en & ~stall;
    assign accept     = advance & in_valid;
    assign term_first = (state_reg == IDLE);
    assign term_last  = (cnt_reg == LAST_TERM);
    assign prod       = a * b;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (accept) begin
            cnt_next = term_last ? '0 : cnt_reg + CNT_W'(1);
            case (state_reg)
                IDLE:    if (KLEN > 1) state_next = ACCUM;
                ACCUM:   if (term_last) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // The first product of a window restarts the sum from the bias captured alongside it.
    assign acc_sum = (p_first ? ACC_W'(bias_r) : acc_reg) + ACC_W'(p_r);

`ifdef MAC_WINDOW_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        if (acc_sum > SAT_MAX)
            result = SAT_MAX[OUT_W-1:0];
        else if (acc_sum < SAT_MIN)
            result = SAT_MIN[OUT_W-1:0];
        else
            result = acc_sum[OUT_W-1:0];
    end
`else
    assign result = acc_sum[OUT_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            p_r       <= '0;
            p_vld     <= 1'b0;
            p_first   <= 1'b0;
            p_last    <= 1'b0;
            bias_r    <= '0;
            acc_reg   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            if (sclr) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                p_vld     <= 1'b0;
                out_valid <= 1'b0;
            end else if (!stall) begin
                state_reg <= state_next;
                cnt_reg   <= cnt_next;
                p_r       <= prod;
                p_vld     <= in_valid;
                p_first   <= term_first;
                p_last    <= term_last;
                if (in_valid && term_first)
                    bias_r <= bias;
                if (p_vld)
                    acc_reg <= acc_sum;
                // Not stalled means any pending result is being taken this edge.
                out_valid <= p_vld & p_last;
                if (p_vld && p_last)
                    out_data <= result;
            end
        end
    end
endmodule

// File: tb/tb_mac_window.sv
// Randomised and directed bench for mac_window against a window-sum reference model.
`timescale 1ns/1ps
module tb_mac_window;
    localparam int K  = 4;
    localparam int OW = 33;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, sclr, in_valid, in_ready, out_valid, out_ready;
    logic signed [15:0]   a, b;
    logic signed [27:0]   bias;
    logic signed [OW-1:0] out_data;

    logic in_valid2, in_ready2, out_valid2;
    logic signed [15:0] a2, b2, out_data2;
    logic signed [27:0] bias2;

    mac_window #(.KLEN(K)) dut (
        .clk(clk), .rst(rst), .en(en), .sclr(sclr),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    mac_window #(.OUT_W(16), .KLEN(2)) dut2 (
        .clk(clk), .rst(rst), .en(1'b1), .sclr(1'b0),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .bias(bias2),
        .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2)
    );

    int errors = 0;
    int checks = 0;
    int n_fired = 0;
    longint exp_q[$];
    int m_cnt;
    longint m_sum;
    logic prev_stall;
    logic signed [OW-1:0] prev_data;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Map an exact sum onto a w-bit signed result.
    function automatic longint conv(input longint s, input int w);
        longint hi, lo, t;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
`ifdef MAC_WINDOW_SAT_EN
        t = (s > hi) ? hi : (s < lo) ? lo : s;
`else
        t = (s <<< (64 - w)) >>> (64 - w);
`endif
        return t;
    endfunction

    // One clock: sample before the edge, update model, advance to next falling edge.
    task automatic cyc();
        logic fire_now, acc_now;
        #1;
        check("in_ready", in_ready, en & ~(out_valid & ~out_ready));
        if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_data);
        end
        fire_now = out_valid & out_ready & en & ~sclr;
        if (fire_now) begin
            if (exp_q.size() == 0)
                check("unexpected_out_valid", out_valid, 0);
            else
                check("out_data", out_data, exp_q.pop_front());
            n_fired++;
        end
        acc_now = in_valid & in_ready & ~sclr;
        if (en && sclr) begin
            m_cnt = 0;
            exp_q.delete();
        end else if (acc_now) begin
            if (m_cnt == 0) m_sum = bias;
            m_sum += longint'(a) * longint'(b);
            m_cnt++;
            if (m_cnt == K) begin
                exp_q.push_back(conv(m_sum, OW));
                m_cnt = 0;
            end
        end
        prev_stall = out_valid & ~out_ready & ~(en & sclr);
        prev_data  = out_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        m_cnt = 0;
        exp_q.delete();
        prev_stall = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pa[4];
        int pb[4];
        int base;
        pa = '{1, 3, -5, 7};
        pb = '{2, 4, -8, -8};
        pb[2] = 6;
        rst = 1'b0; en = 1'b1; sclr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; bias = '0;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; bias2 = '0;
        m_cnt = 0; m_sum = 0; prev_stall = 1'b0; prev_data = '0;

        @(negedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_valid2", out_valid2, 0);
        rst = 1'b1;
        @(negedge clk);

        // Directed window: bias only taken with the first pair.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = 16'(pa[i]); b = 16'(pb[i]);
            bias = (i == 0) ? 28'sd10 : 28'sd999;
            cyc();
        end
        in_valid = 1'b0;
        check("latency_cycle1", out_valid, 0);
        cyc();
        check("latency_cycle2", out_valid, 1);
        check("directed_sum", out_data, -62);
        cyc();
        check("single_cycle_valid", out_valid, 0);

        // Back-to-back windows with no bubble.
        base = n_fired;
        in_valid = 1'b1; a = 16'sd1; b = 16'sd1; bias = '0;
        for (int i = 0; i < 2 * K; i++) cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        check("b2b_results", n_fired - base, 2);

        // Downstream stall while the next window streams.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom); b = 16'($urandom); bias = 28'($urandom);
            cyc();
        end
        check("stall_in_ready", in_ready, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 12; i++) cyc();

        // Reset mid-window discards the partial sum.
        in_valid = 1'b1; a = 16'sd1; b = 16'sd1; bias = '0;
        cyc(); cyc();
        in_valid = 1'b0;
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < K; i++) cyc();
        in_valid = 1'b0;
        cyc();
        check("post_reset_valid", out_valid, 1);
        check("post_reset_sum", out_data, 4);
        cyc(); cyc();

        // Clock enable low mid-window.
        in_valid = 1'b1;
        for (int i = 0; i < K + 3; i++) begin
            en = !(i >= 2 && i < 5);
            a = 16'($urandom); b = 16'($urandom); bias = 28'($urandom);
            cyc();
        end
        en = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cyc();

        // Synchronous clear mid-window: no result for that window.
        in_valid = 1'b1;
        cyc(); cyc();
        in_valid = 1'b0; sclr = 1'b1;
        cyc();
        sclr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("sclr_no_valid", out_valid, 0);
            cyc();
        end

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 9) != 0);
            sclr      = ($urandom_range(0, 49) == 0);
            a = 16'($urandom); b = 16'($urandom); bias = 28'($urandom);
            cyc();
        end
        en = 1'b1; sclr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        check("drain_empty", exp_q.size(), 0);

        // Narrow output: wrap or saturate at 16 bits.
        in_valid2 = 1'b1; a2 = 16'sd32767; b2 = 16'sd32767; bias2 = '0;
        cyc(); cyc();
        in_valid2 = 1'b0;
        for (int i = 0; i < 8 && !out_valid2; i++) cyc();
        check("narrow_pos_valid", out_valid2, 1);
        check("narrow_pos_data", out_data2, conv(64'sd2147352578, 16));
        cyc();
        in_valid2 = 1'b1; a2 = -16'sd32768; b2 = 16'sd32767;
        cyc(); cyc();
        in_valid2 = 1'b0;
        for (int i = 0; i < 8 && !out_valid2; i++) cyc();
        check("narrow_neg_valid", out_valid2, 1);
        check("narrow_neg_data", out_data2, conv(-64'sd2147418112, 16));
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
